// File: rtl/image_conv_sequencer_pkg.sv
// rtl/image_conv_sequencer_pkg.sv - command/state encodings shared by the convolution job sequencer
package image_conv_sequencer_pkg;

    localparam logic [3:0] CMD_NONE = 4'b0000;
    localparam logic [3:0] CMD_PARA = 4'b0001;
    localparam logic [3:0] CMD_COMP = 4'b0010;
    localparam logic [3:0] CMD_ACK  = 4'b1111;

    localparam logic [3:0] ST_IDLE = 4'b0000;
    localparam logic [3:0] ST_PARA = 4'b0001;
    localparam logic [3:0] ST_COMP = 4'b0010;
    localparam logic [3:0] ST_IRQ  = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PARA_REQ  = 3'd1,
        S_PARA_WAIT = 3'd2,
        S_PARA_ACK  = 3'd3,
        S_COMP_REQ  = 3'd4,
        S_COMP_WAIT = 3'd5,
        S_COMP_ACK  = 3'd6,
        S_ERR       = 3'd7
    } seq_state_e;

    function automatic logic [3:0] cmd_for_state(input seq_state_e s);
        case (s)
            S_PARA_REQ: return CMD_PARA;
            S_COMP_REQ: return CMD_COMP;
            S_PARA_ACK,
            S_COMP_ACK: return CMD_ACK;
            default:    return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/image_conv_sequencer_if.sv
// rtl/image_conv_sequencer_if.sv - 4-bit Control/State handshake between sequencer and engine
interface image_conv_sequencer_if;
    logic [3:0] State;
    logic [3:0] Control;

    modport master (output Control, input State);
    modport slave  (input Control, output State);
endinterface

// File: rtl/image_seq_watchdog.sv
// rtl/image_seq_watchdog.sv - clearable handshake watchdog; expires on the cycle the count reaches HS_TIMEOUT
module image_seq_watchdog #(
    parameter int TO_W       = 16,
    parameter int HS_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LAST_CNT = TO_W'(HS_TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/image_conv_sequencer.sv
// rtl/image_conv_sequencer.sv - multi-layer job sequencer driving the convolution engine Control/State handshake
module image_conv_sequencer
    import image_conv_sequencer_pkg::*;
#(
    parameter int LAYER_W    = 8,
    parameter int TO_W       = 16,
    parameter int HS_TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [LAYER_W-1:0]         layer_num,
    image_conv_sequencer_if.master     eng,
    output logic [LAYER_W-1:0]         layer_idx,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    seq_state_e         state_q, state_d;
    logic [LAYER_W-1:0] num_q;
    logic [LAYER_W-1:0] idx_q;
    logic [3:0]         ctl_q;
    logic               busy_q, done_q, err_q;

    logic accept, finish, zero_job, next_layer, last_layer;
    logic wd_en, wd_clr, wd_expire;

    assign last_layer = (idx_q == num_q - LAYER_W'(1));
    assign wd_en = (state_q == S_PARA_REQ) || (state_q == S_PARA_ACK) ||
                   (state_q == S_COMP_REQ) || (state_q == S_COMP_ACK);
    assign wd_clr = (state_d != state_q);

    image_seq_watchdog #(
        .TO_W       (TO_W),
        .HS_TIMEOUT (HS_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    // A State match always wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        finish     = 1'b0;
        zero_job   = 1'b0;
        next_layer = 1'b0;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (layer_num != '0) begin
                            state_d = S_PARA_REQ;
                            accept  = 1'b1;
                        end else begin
                            zero_job = 1'b1;
                        end
                    end
                end
                S_PARA_REQ: begin
                    if (eng.State == ST_PARA)  state_d = S_PARA_WAIT;
                    else if (wd_expire)        state_d = S_ERR;
                end
                S_PARA_WAIT: begin
                    if (eng.State == ST_IRQ)   state_d = S_PARA_ACK;
                end
                S_PARA_ACK: begin
                    if (eng.State == ST_IDLE)  state_d = S_COMP_REQ;
                    else if (wd_expire)        state_d = S_ERR;
                end
                S_COMP_REQ: begin
                    if (eng.State == ST_COMP)  state_d = S_COMP_WAIT;
                    else if (wd_expire)        state_d = S_ERR;
                end
                S_COMP_WAIT: begin
                    if (eng.State == ST_IRQ)   state_d = S_COMP_ACK;
                end
                S_COMP_ACK: begin
                    if (eng.State == ST_IDLE) begin
                        if (last_layer) begin
                            state_d = S_IDLE;
                            finish  = 1'b1;
                        end else begin
                            state_d    = S_PARA_REQ;
                            next_layer = 1'b1;
                        end
                    end else if (wd_expire) begin
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    if (start) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctl_q   <= CMD_NONE;
            num_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= cmd_for_state(state_d);
            busy_q  <= (state_d != S_IDLE) && (state_d != S_ERR);
            done_q  <= finish || zero_job;
            if (accept) begin
                num_q <= layer_num;
                idx_q <= '0;
                err_q <= 1'b0;
            end else begin
                if (next_layer) begin
                    idx_q <= idx_q + LAYER_W'(1);
                end
                if ((state_d == S_ERR) && (state_q != S_ERR)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign eng.Control = ctl_q;
    assign layer_idx   = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;

endmodule

// File: tb/tb_image_conv_sequencer.sv
// tb/tb_image_conv_sequencer.sv - directed table-driven bench with a 2-cycle-lag engine model
module tb_image_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort, freeze, rec_en;
    logic [7:0] layer_num;
    logic [7:0] layer_idx;
    logic       busy, done, error;
    logic [3:0] Control;
    logic [3:0] eng_st, ctl_d1;
    logic [1:0] ecnt;

    int n_pass = 0;
    int n_total = 0;

    logic [3:0] ctl_log[$];
    logic [7:0] idx_log[$];
    logic [3:0] prev_ctl;
    int         done_cnt;
    logic [3:0] pat[6];

    typedef struct {
        logic [7:0] n;
        bit         mid_start;
        int         exp_changes;
        int         exp_done;
    } vec_t;
    vec_t vecs[4];

    image_conv_sequencer_if eng_if();
    assign eng_if.State = eng_st;
    assign Control = eng_if.Control;

    image_conv_sequencer #(
        .LAYER_W    (8),
        .TO_W       (16),
        .HS_TIMEOUT (1023)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .layer_num (layer_num),
        .eng       (eng_if),
        .layer_idx (layer_idx),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Engine: sees Control one cycle late, spends 3 cycles per phase, then raises IRQ until acked.
    always @(posedge clk) begin
        ctl_d1 <= Control;
        if (rst || freeze) begin
            eng_st <= 4'h0;
            ecnt   <= 2'd0;
        end else begin
            case (eng_st)
                4'h0: begin
                    ecnt <= 2'd0;
                    if (ctl_d1 == 4'h1)      eng_st <= 4'h1;
                    else if (ctl_d1 == 4'h2) eng_st <= 4'h2;
                end
                4'h1, 4'h2: begin
                    if (ecnt == 2'd2) eng_st <= 4'hF;
                    else              ecnt   <= ecnt + 2'd1;
                end
                4'hF: if (ctl_d1 == 4'hF) eng_st <= 4'h0;
                default: eng_st <= 4'h0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rec_en) begin
            if (Control !== prev_ctl) begin
                ctl_log.push_back(Control);
                idx_log.push_back(layer_idx);
            end
            prev_ctl = Control;
            if (done) done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_ctl(input logic [3:0] v, input string name);
        int c = 0;
        while (Control !== v && c < 200) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(c < 200), 32'd1);
    endtask

    task automatic run_row(input vec_t v);
        int         cyc;
        int         n;
        logic [3:0] ctl_at[4];
        logic [3:0] exp_c;
        logic [7:0] exp_i;
        bit         busy_drop;
        logic       t1_busy, t1_err;
        n = int'(v.n);
        ctl_log.delete();
        idx_log.delete();
        done_cnt  = 0;
        prev_ctl  = Control;
        busy_drop = 1'b0;
        for (int i = 0; i < 4; i++) ctl_at[i] = 4'h0;
        @(negedge clk);
        layer_num = v.n;
        start     = 1'b1;
        rec_en    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        t1_busy = busy;
        t1_err  = error;
        cyc     = 0;
        while (!done && cyc < 3000) begin
            if (cyc < 4) ctl_at[cyc] = Control;
            if (!busy) busy_drop = 1'b1;
            if (v.mid_start && cyc == 5) begin
                layer_num = 8'd9;
                start     = 1'b1;
            end else if (cyc == 6) begin
                start     = 1'b0;
                layer_num = v.n;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check($sformatf("job%0d_done_seen", n), 32'(cyc < 3000), 32'd1);
        check($sformatf("job%0d_busy_at_done", n), 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rec_en = 1'b0;
        check($sformatf("job%0d_done_pulses", n), 32'(done_cnt), 32'(v.exp_done));
        check($sformatf("job%0d_ctl_changes", n), 32'(ctl_log.size()), 32'(v.exp_changes));
        check($sformatf("job%0d_error", n), 32'(error), 32'd0);
        check($sformatf("job%0d_ctl_final", n), 32'(Control), 32'd0);
        if (n == 0) begin
            check("job0_done_at_t1", 32'(cyc), 32'd0);
            check("job0_busy_t1", 32'(t1_busy), 32'd0);
        end else begin
            check($sformatf("job%0d_busy_t1", n), 32'(t1_busy), 32'd1);
            check($sformatf("job%0d_err_cleared_t1", n), 32'(t1_err), 32'd0);
            check($sformatf("job%0d_busy_steady", n), 32'(busy_drop), 32'd0);
            check($sformatf("job%0d_ctl_t1", n), 32'(ctl_at[0]), 32'h1);
            check($sformatf("job%0d_ctl_t3", n), 32'(ctl_at[2]), 32'h1);
            check($sformatf("job%0d_ctl_t4", n), 32'(ctl_at[3]), 32'h0);
        end
        for (int k = 0; k < ctl_log.size() && k < v.exp_changes; k++) begin
            exp_c = (k == 6 * n) ? 4'h0 : pat[k % 6];
            exp_i = (k < 6 * n) ? 8'(k / 6) : 8'(n - 1);
            check($sformatf("job%0d_ctl_seq[%0d]", n, k), 32'(ctl_log[k]), 32'(exp_c));
            check($sformatf("job%0d_idx_seq[%0d]", n, k), 32'(idx_log[k]), 32'(exp_i));
        end
    endtask

    initial begin
        pat[0] = 4'h1; pat[1] = 4'h0; pat[2] = 4'hF;
        pat[3] = 4'h2; pat[4] = 4'h0; pat[5] = 4'hF;
        vecs[0] = '{n: 8'd1, mid_start: 1'b0, exp_changes: 7,  exp_done: 1};
        vecs[1] = '{n: 8'd3, mid_start: 1'b0, exp_changes: 19, exp_done: 1};
        vecs[2] = '{n: 8'd0, mid_start: 1'b0, exp_changes: 0,  exp_done: 1};
        vecs[3] = '{n: 8'd2, mid_start: 1'b1, exp_changes: 13, exp_done: 1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; freeze = 1'b0;
        rec_en = 1'b0; layer_num = 8'd0; done_cnt = 0; prev_ctl = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_control", 32'(Control), 32'h0);
        check("rst_layer_idx", 32'(layer_idx), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 4; r++) run_row(vecs[r]);

        // Watchdog: engine frozen idle, PARA_REQ lasts 1023 cycles.
        freeze = 1'b1;
        @(negedge clk);
        layer_num = 8'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("to_ctl_t1", 32'(Control), 32'h1);
        check("to_busy_t1", 32'(busy), 32'h1);
        repeat (1022) @(negedge clk);
        check("to_ctl_last_req", 32'(Control), 32'h1);
        check("to_err_before", 32'(error), 32'h0);
        @(negedge clk);
        check("to_err_set", 32'(error), 32'h1);
        check("to_busy_err", 32'(busy), 32'h0);
        check("to_ctl_err", 32'(Control), 32'h0);
        repeat (5) @(negedge clk);
        check("to_err_hold", 32'(error), 32'h1);
        check("to_ctl_hold", 32'(Control), 32'h0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("to_leave_err_sticky", 32'(error), 32'h1);
        check("to_leave_err_busy", 32'(busy), 32'h0);
        check("to_leave_err_ctl", 32'(Control), 32'h0);
        freeze = 1'b0;
        run_row('{n: 8'd2, mid_start: 1'b0, exp_changes: 13, exp_done: 1});

        // Abort in COMP_WAIT.
        done_cnt = 0;
        prev_ctl = Control;
        rec_en   = 1'b1;
        @(negedge clk);
        layer_num = 8'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ctl(4'h2, "ab_reach_comp_req");
        wait_ctl(4'h0, "ab_reach_comp_wait");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_ctl", 32'(Control), 32'h0);
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_done", 32'(done), 32'h0);
        repeat (6) @(negedge clk);
        rec_en = 1'b0;
        check("ab_no_done", 32'(done_cnt), 32'd0);
        check("ab_ctl_idle", 32'(Control), 32'h0);
        freeze = 1'b1;
        @(negedge clk);
        freeze = 1'b0;

        // Reset while in PARA_ACK.
        @(negedge clk);
        layer_num = 8'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ctl(4'h1, "rs_reach_para_req");
        wait_ctl(4'hF, "rs_reach_para_ack");
        rst = 1'b1;
        @(negedge clk);
        check("rs_control", 32'(Control), 32'h0);
        check("rs_layer_idx", 32'(layer_idx), 32'h0);
        check("rs_busy", 32'(busy), 32'h0);
        check("rs_done", 32'(done), 32'h0);
        check("rs_error", 32'(error), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        run_row('{n: 8'd1, mid_start: 1'b0, exp_changes: 7, exp_done: 1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
